// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT0 = 2'b01,
    S_GNT1 = 2'b10
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_DC = 1'b1;  // data cache controller

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way request picker for the SRAM arbiter.
// Tie rule selected by ARB_ROUND_ROBIN_EN: defined -> alternate against
// last_owner, undefined -> the data port always wins.
module rr_pick2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last_owner,
  input  logic [1:0] exclude,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] w_elig;

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = last_owner;
`endif

  // Choose one eligible requester; a completing owner is masked via exclude.
  always_comb begin
    w_elig      = pending & ~exclude;
    grant_valid = |w_elig;
    grant_idx   = PORT_IF;
    unique case (w_elig)
      2'b01:   grant_idx = PORT_IF;
      2'b10:   grant_idx = PORT_DC;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   grant_idx = ~last_owner;
`else
      2'b11:   grant_idx = PORT_DC;
`endif
      default: grant_idx = PORT_IF;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between instruction fetch (port 0) and the
// data cache controller (port 1). Grant held per transaction until sram_ready.
// Optional: ARB_ROUND_ROBIN_EN selects round-robin ties (see rr_pick2).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p0_address,
  input  logic [31:0] p1_address,
  input  logic [31:0] p0_write_data,
  input  logic [31:0] p1_write_data,
  input  logic        p0_r_en,
  input  logic        p0_w_en,
  input  logic        p1_r_en,
  input  logic        p1_w_en,
  output logic [63:0] p0_rdata,
  output logic [63:0] p1_rdata,
  output logic        p0_ready,
  output logic        p1_ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  output logic        sram_read_en,
  output logic        sram_write_en,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready,
  output logic        timeout_err
);

  localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES);

  arb_state_e r_state;
  arb_state_e w_next;
  logic [7:0] r_cnt;
  logic       r_last_owner;
  logic       r_timeout_err;

  logic       w_pend0;
  logic       w_pend1;
  logic [1:0] w_exclude;
  logic       w_pick_valid;
  logic       w_pick_idx;
  logic       w_granted;
  logic       w_owner_pend;
  logic [8:0] w_cnt_inc;

  assign w_pend0      = p0_r_en | p0_w_en;
  assign w_pend1      = p1_r_en | p1_w_en;
  assign w_granted    = (r_state == S_GNT0) | (r_state == S_GNT1);
  assign w_owner_pend = (r_state == S_GNT0) ? w_pend0 : w_pend1;
  assign w_exclude    = {(r_state == S_GNT1), (r_state == S_GNT0)};
  assign w_cnt_inc    = {1'b0, r_cnt} + 9'd1;

  assign p0_ready    = ~w_pend0 | ((r_state == S_GNT0) & sram_ready);
  assign p1_ready    = ~w_pend1 | ((r_state == S_GNT1) & sram_ready);
  assign timeout_err = r_timeout_err;

  rr_pick2 u_pick (
    .pending     ({w_pend1, w_pend0}),
    .last_owner  (r_last_owner),
    .exclude     (w_exclude),
    .grant_valid (w_pick_valid),
    .grant_idx   (w_pick_idx)
  );

  // Next state, SRAM drive and read-data return for the current owner.
  always_comb begin
    w_next          = r_state;
    sram_address    = '0;
    sram_write_data = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    p0_rdata        = '0;
    p1_rdata        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_valid) w_next = w_pick_idx ? S_GNT1 : S_GNT0;
      end
      S_GNT0: begin
        sram_address    = p0_address;
        sram_write_data = p0_write_data;
        sram_write_en   = p0_w_en;
        sram_read_en    = p0_r_en & ~p0_w_en;
        if (!w_pend0) begin
          w_next = S_IDLE;
        end else if (sram_ready) begin
          if (p0_r_en & ~p0_w_en) p0_rdata = sram_read_data;
          w_next = w_pick_valid ? S_GNT1 : S_IDLE;
        end
      end
      S_GNT1: begin
        sram_address    = p1_address;
        sram_write_data = p1_write_data;
        sram_write_en   = p1_w_en;
        sram_read_en    = p1_r_en & ~p1_w_en;
        if (!w_pend1) begin
          w_next = S_IDLE;
        end else if (sram_ready) begin
          if (p1_r_en & ~p1_w_en) p1_rdata = sram_read_data;
          w_next = w_pick_valid ? S_GNT0 : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, last owner and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_owner  <= PORT_DC;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_granted & w_owner_pend & ~sram_ready) begin
        if (r_cnt != LP_TMO) r_cnt <= w_cnt_inc[7:0];
        if (w_cnt_inc >= {1'b0, LP_TMO}) r_timeout_err <= 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_granted & w_owner_pend & sram_ready) r_last_owner <= (r_state == S_GNT1);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_sram_arbiter;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p0_address, p1_address, p0_write_data, p1_write_data;
  logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en;
  logic [63:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic [31:0] sram_address, sram_write_data;
  logic        sram_read_en, sram_write_en;
  logic [63:0] sram_read_data;
  logic        sram_ready;
  logic        timeout_err;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_address(p0_address), .p1_address(p1_address),
    .p0_write_data(p0_write_data), .p1_write_data(p1_write_data),
    .p0_r_en(p0_r_en), .p0_w_en(p0_w_en), .p1_r_en(p1_r_en), .p1_w_en(p1_w_en),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready),
    .timeout_err(timeout_err)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: who owns the SRAM (-1 = nobody), who finished last,
  // how long the owner has waited, and the sticky timeout flag.
  int          m_owner = -1;
  int          m_last  = 1;
  int unsigned m_cnt   = 0;
  bit          m_err   = 1'b0;

  int unsigned obs_done0, obs_done1;
  bit          exp_done0, exp_done1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit pa, input bit pb, input int last);
    if (pa && pb) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return 1;
`endif
    end
    if (pa) return 0;
    if (pb) return 1;
    return -1;
  endfunction

  task automatic set_req(input int p, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    if (p == 0) begin
      p0_r_en = r; p0_w_en = w; p0_address = a; p0_write_data = d;
    end else begin
      p1_r_en = r; p1_w_en = w; p1_address = a; p1_write_data = d;
    end
  endtask

  task automatic clr(input int p);
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock cycle: inputs already applied; check at negedge, then advance model.
  task automatic tick();
    bit          pd[2], rd[2], wr[2], e_rdy[2];
    logic [31:0] ad[2], wd[2];
    logic [63:0] e_rdata[2];
    logic [31:0] e_addr, e_wd;
    bit          e_re, e_we;
    int          o;
    rd[0] = p0_r_en; wr[0] = p0_w_en; ad[0] = p0_address; wd[0] = p0_write_data;
    rd[1] = p1_r_en; wr[1] = p1_w_en; ad[1] = p1_address; wd[1] = p1_write_data;
    for (int i = 0; i < 2; i++) pd[i] = rd[i] | wr[i];
    if (!rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0; m_err = 1'b0;
    end
    @(negedge clk);
    e_addr = '0; e_wd = '0; e_re = 1'b0; e_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rdy[i]   = !pd[i] || (m_owner == i && sram_ready);
      e_rdata[i] = (m_owner == i && sram_ready && rd[i] && !wr[i]) ? sram_read_data : 64'h0;
    end
    if (m_owner >= 0) begin
      e_addr = ad[m_owner]; e_wd = wd[m_owner];
      e_we = wr[m_owner]; e_re = rd[m_owner] && !wr[m_owner];
    end
    chk("p0_ready", p0_ready, e_rdy[0]);
    chk("p1_ready", p1_ready, e_rdy[1]);
    chk("p0_rdata", p0_rdata, e_rdata[0]);
    chk("p1_rdata", p1_rdata, e_rdata[1]);
    chk("sram_address", sram_address, e_addr);
    chk("sram_write_data", sram_write_data, e_wd);
    chk("sram_read_en", sram_read_en, e_re);
    chk("sram_write_en", sram_write_en, e_we);
    chk("timeout_err", timeout_err, m_err);
    if (p0_ready && pd[0]) obs_done0++;
    if (p1_ready && pd[1]) obs_done1++;
    exp_done0 = pd[0] && e_rdy[0];
    exp_done1 = pd[1] && e_rdy[1];
    if (rst) begin
      if (m_owner < 0) begin
        m_owner = pick(pd[0], pd[1], m_last);
      end else if (!pd[m_owner]) begin
        m_owner = -1; m_cnt = 0;
      end else if (sram_ready) begin
        o = m_owner; m_last = o; m_cnt = 0;
        m_owner = pick(pd[0] && o != 0, pd[1] && o != 1, o);
      end else begin
        if (m_cnt < TMO) m_cnt++;
        if (m_cnt >= TMO) m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned iss0, iss1;
    bit          r, w;
    rst = 1'b0;
    clr(0); clr(1);
    sram_ready = 1'b0; sram_read_data = '0;
    #1;
    tick();
    chk("reset_timeout", timeout_err, 1'b0);
    rst = 1'b1;
    tick();

    // Single read on port 0, SRAM answers on the third grant cycle.
    obs_done0 = 0; obs_done1 = 0;
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
    sram_read_data = {$urandom, $urandom};
    tick();
    tick();
    tick();
    sram_ready = 1'b1; sram_read_data = 64'h11112222_33334444;
    tick();
    clr(0); sram_ready = 1'b0;
    tick();
    chk("t1_done0", obs_done0, 1);
    chk("t1_done1", obs_done1, 0);

    // Simultaneous p0 read / p1 write straight out of reset.
    rst = 1'b0; tick(); rst = 1'b1;
    obs_done0 = 0; obs_done1 = 0;
    set_req(0, 1'b1, 1'b0, 32'h500, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'h600, 32'hDEADBEEF);
    sram_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sram_read_data = {$urandom, $urandom};
      tick();
      if (exp_done0) clr(0);
      if (exp_done1) clr(1);
    end
    chk("t2_done0", obs_done0, 1);
    chk("t2_done1", obs_done1, 1);

    // Four back-to-back requests per port.
    obs_done0 = 0; obs_done1 = 0;
    iss0 = 1; iss1 = 1;
    set_req(0, 1'b1, 1'b0, $urandom, $urandom);
    set_req(1, 1'b0, 1'b1, $urandom, $urandom);
    for (int k = 0; k < 40; k++) begin
      sram_read_data = {$urandom, $urandom};
      tick();
      if (exp_done0) begin
        if (iss0 < 4) begin set_req(0, 1'b1, 1'b0, $urandom, $urandom); iss0++; end
        else clr(0);
      end
      if (exp_done1) begin
        if (iss1 < 4) begin set_req(1, 1'b0, 1'b1, $urandom, $urandom); iss1++; end
        else clr(1);
      end
    end
    chk("t3_done0", obs_done0, 4);
    chk("t3_done1", obs_done1, 4);

    // Read and write both set on port 1: write wins.
    obs_done1 = 0;
    sram_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h700, 32'hCAFEF00D);
    tick();
    tick();
    sram_ready = 1'b1;
    tick();
    clr(1); sram_ready = 1'b0;
    tick();
    chk("t4_done1", obs_done1, 1);

    // Grant starved of sram_ready for 300 cycles.
    obs_done0 = 0;
    set_req(0, 1'b1, 1'b0, 32'h800, 32'h0);
    for (int k = 0; k < 300; k++) tick();
    chk("t5_err_set", timeout_err, 1'b1);
    sram_ready = 1'b1; sram_read_data = 64'h0123456789ABCDEF;
    tick();
    clr(0); sram_ready = 1'b0;
    tick();
    chk("t5_err_sticky", timeout_err, 1'b1);
    chk("t5_done0", obs_done0, 1);

    // Asynchronous reset in the middle of a grant.
    set_req(0, 1'b1, 1'b0, 32'h900, 32'h0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_re", sram_read_en, 1'b0);
    chk("t6_async_err", timeout_err, 1'b0);
    chk("t6_async_addr", sram_address, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    sram_ready = 1'b1;
    tick();
    clr(0); sram_ready = 1'b0;
    tick();

    // Random traffic with occasional dropped requests.
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++) begin
        bit act;
        act = (p == 0) ? (p0_r_en | p0_w_en) : (p1_r_en | p1_w_en);
        if (!act && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       begin r = 1'b1; w = 1'b0; end
            1:       begin r = 1'b0; w = 1'b1; end
            default: begin r = 1'b1; w = 1'b1; end
          endcase
          set_req(p, r, w, $urandom, $urandom);
        end else if (act && $urandom_range(0, 199) == 0) begin
          clr(p);
        end
      end
      sram_ready     = 1'($urandom_range(0, 1));
      sram_read_data = {$urandom, $urandom};
      tick();
      if (exp_done0) clr(0);
      if (exp_done1) clr(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
